// File: rtl/usb_bulk_in_packetizer.sv
// usb_bulk_in_packetizer
// Turns an application byte stream into full-speed bulk IN packets for one
// IN endpoint of usb_fs_pe. Full packets commit as soon as MAX_PACKET bytes
// are written. Partial packets commit once FLUSH_FRAMES SOFs pass without a
// new byte. A zero-length packet follows a full packet that ended a transfer.
module usb_bulk_in_packetizer #(
    parameter int MAX_PACKET   = 32,
    parameter int FLUSH_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,

    // application stream
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,

    // protocol engine IN endpoint
    output logic        in_ep_req,
    input  logic        in_ep_grant,
    input  logic        in_ep_data_free,
    output logic        in_ep_data_put,
    output logic [7:0]  in_ep_data,
    output logic        in_ep_data_done,
    output logic        in_ep_stall,
    input  logic        in_ep_acked,

    // frame timing
    input  logic        sof_valid,

    // status
    output logic [15:0] pkts_sent
);

    localparam int            CW        = $clog2(MAX_PACKET + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PACKET);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_PACKET - 1);
    localparam logic [7:0]    FLUSH_N   = 8'(FLUSH_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FILL     = 2'd1,
        S_COMMIT   = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     sof_cnt_q, sof_cnt_d;
    logic           zlp_pending_q, zlp_pending_d;
    logic           last_full_q, last_full_d;
    logic [15:0]    pkts_sent_q, pkts_sent_d;

    logic           byte_put;
    logic [7:0]     sof_next;
    logic           have_payload;

    // Handshake decode and endpoint-facing outputs; the byte path is a wire.
    always_comb begin
        in_ep_req       = (state_q != S_IDLE);
        in_ready        = (state_q == S_FILL) && in_ep_grant && in_ep_data_free
                          && (count_q < CNT_MAX);
        byte_put        = in_valid && in_ready;
        in_ep_data_put  = byte_put;
        in_ep_data      = in_data;
        in_ep_data_done = (state_q == S_COMMIT);
        in_ep_stall     = 1'b0;
        pkts_sent       = pkts_sent_q;
        // sof_cnt saturates so a long idle stretch never wraps back below
        // the flush threshold.
        sof_next        = (sof_cnt_q >= FLUSH_N) ? FLUSH_N : (sof_cnt_q + 8'd1);
        // Something worth committing: real bytes, or an owed ZLP.
        have_payload    = (count_q != '0) || zlp_pending_q;
    end

    // Next-state logic: packet filling, SOF flush timeout and ACK tracking.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        sof_cnt_d     = sof_cnt_q;
        zlp_pending_d = zlp_pending_q;
        last_full_d   = last_full_q;
        pkts_sent_d   = pkts_sent_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid || zlp_pending_q) begin
                    state_d   = S_FILL;
                    sof_cnt_d = '0;
                end
            end

            S_FILL: begin
                if (byte_put) begin
                    // A written byte restarts the idle timer and cancels any
                    // owed ZLP: the data itself now terminates the transfer.
                    count_d       = count_q + CW'(1);
                    sof_cnt_d     = '0;
                    zlp_pending_d = 1'b0;
                    if (count_q == CNT_LAST) begin
                        state_d     = S_COMMIT;
                        last_full_d = 1'b1;
                    end
                end else if (sof_valid) begin
                    sof_cnt_d = sof_next;
                    if ((sof_next == FLUSH_N) && have_payload) begin
                        state_d     = S_COMMIT;
                        last_full_d = 1'b0;
                    end else if (!have_payload) begin
                        // Nothing buffered and nothing owed: release the
                        // datapath request until the stream wakes up again.
                        state_d = S_IDLE;
                    end
                end
            end

            S_COMMIT: begin
                count_d   = '0;
                sof_cnt_d = '0;
                state_d   = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (in_ep_acked) begin
                    pkts_sent_d   = pkts_sent_q + 16'd1;
                    zlp_pending_d = last_full_q;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            sof_cnt_q     <= '0;
            zlp_pending_q <= 1'b0;
            last_full_q   <= 1'b0;
            pkts_sent_q   <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sof_cnt_q     <= sof_cnt_d;
            zlp_pending_q <= zlp_pending_d;
            last_full_q   <= last_full_d;
            pkts_sent_q   <= pkts_sent_d;
        end
    end

endmodule

// File: tb/tb_usb_bulk_in_packetizer.sv
// Bench for usb_bulk_in_packetizer with MAX_PACKET=8, FLUSH_FRAMES=2.
// A host/stream model feeds bytes, pulses SOF and ACKs committed packets;
// each scenario compares the observed packet list against the packets the
// stream should produce.
module tb_usb_bulk_in_packetizer;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_ep_req;
    logic        in_ep_grant;
    logic        in_ep_data_free;
    logic        in_ep_data_put;
    logic [7:0]  in_ep_data;
    logic        in_ep_data_done;
    logic        in_ep_stall;
    logic        in_ep_acked;
    logic        sof_valid;
    logic [15:0] pkts_sent;

    usb_bulk_in_packetizer #(.MAX_PACKET(8), .FLUSH_FRAMES(2)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .sof_valid(sof_valid), .pkts_sent(pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  sent_q[$];
    logic [7:0]  cur[$];
    logic [7:0]  rx_q[$];
    int          pkt_size[$];
    int          pkt_first[$];
    int          done_cyc[$];
    int          cur_first = -1;
    int          put_total = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_put_cyc = -1;
    int          valid_pct = 100;
    int          sof_period = 0;
    int          ack_lat = 2;
    int          ack_timer = 0;
    bit          auto_ack = 1'b1;
    logic        s_req, s_ready, s_done;
    logic [15:0] exp_pkts = 16'd0;

    // One clock cycle: sample the cycle's outputs mid-low-phase, then at the
    // next falling edge apply the stream/SOF/ACK inputs of the next cycle.
    task automatic tick();
        #3;
        s_req = in_ep_req; s_ready = in_ready; s_done = in_ep_data_done;
        if (in_valid && in_ready && tx_q.size() > 0) void'(tx_q.pop_front());
        if (in_ep_data_put) begin
            if (cur.size() == 0) cur_first = cyc;
            cur.push_back(in_ep_data);
            put_total++;
            last_put_cyc = cyc;
        end
        if (in_ep_data_done) begin
            pkt_size.push_back(cur.size());
            pkt_first.push_back(cur.size() == 0 ? -1 : cur_first);
            done_cyc.push_back(cyc);
            foreach (cur[i]) rx_q.push_back(cur[i]);
            cur.delete();
            done_cnt++;
            ack_timer = ack_lat;
        end
        @(negedge clk);
        cyc++;
        in_valid  = (tx_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
        in_data   = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
        sof_valid = (sof_period != 0) && ((cyc % sof_period) == 0);
        in_ep_acked = 1'b0;
        if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0 && auto_ack) in_ep_acked = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_sof();
        sof_valid = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        tx_q.push_back(b);
        sent_q.push_back(b);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        in_ep_grant = 1'b1; in_ep_data_free = 1'b1; in_ep_acked = 1'b0; sof_valid = 1'b0;
        @(negedge clk);
        #3;
        n_cmp++; if (in_ep_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", in_ep_req); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        n_cmp++; if (in_ep_data_put !== 1'b0) begin n_fail++; $display("FAIL reset_put: got %b want 0", in_ep_data_put); end
        n_cmp++; if (in_ep_data_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", in_ep_data_done); end
        n_cmp++; if (pkts_sent !== 16'd0) begin n_fail++; $display("FAIL reset_pkts: got %0d want 0", pkts_sent); end
        n_cmp++; if (in_ep_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", in_ep_stall); end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        run(4);
    endtask

    task automatic test_full_zlp();
        int d0, p0, r0, sc;
        d0 = done_cnt; p0 = put_total; r0 = rx_q.size();
        for (int i = 0; i < 8; i++) send(8'(i));
        for (int k = 0; k < 50 && done_cnt == d0; k++) tick();
        n_cmp++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (pkt_size[$] != 8) begin n_fail++; $display("FAIL full_size: got %0d want 8", pkt_size[$]); end
        n_cmp++; if (last_put_cyc - pkt_first[$] != 7) begin n_fail++; $display("FAIL full_b2b: put span %0d want 7", last_put_cyc - pkt_first[$]); end
        n_cmp++; if (done_cyc[$] != last_put_cyc + 1) begin n_fail++; $display("FAIL full_done_lat: done at %0d want %0d", done_cyc[$], last_put_cyc + 1); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rx_q[r0 + i] !== 8'(i)) begin n_fail++; $display("FAIL full_byte%0d: got %h want %h", i, rx_q[r0 + i], 8'(i)); end
        end
        run(6);
        exp_pkts++;
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL full_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
        pulse_sof();
        run(3);
        n_cmp++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL zlp_early: got %0d dones want 1", done_cnt - d0); end
        sc = cyc;
        pulse_sof();
        tick();
        n_cmp++; if (done_cnt != d0 + 2 || done_cyc[$] != sc + 1) begin n_fail++; $display("FAIL zlp_done: dones %0d at %0d want 2 at %0d", done_cnt - d0, done_cyc[$], sc + 1); end
        n_cmp++; if (pkt_size[$] != 0 || put_total != p0 + 8) begin n_fail++; $display("FAIL zlp_size: size %0d puts %0d want 0 and 8", pkt_size[$], put_total - p0); end
        run(6);
        exp_pkts++;
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL zlp_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
    endtask

    task automatic test_partial_flush();
        int d0, p0, r0, sc;
        d0 = done_cnt; p0 = put_total; r0 = rx_q.size();
        send(8'hA1); send(8'hA2); send(8'hA3);
        for (int k = 0; k < 20 && put_total < p0 + 3; k++) tick();
        run(2);
        pulse_sof();
        run(4);
        n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL partial_early: got %0d dones want 0", done_cnt - d0); end
        sc = cyc;
        pulse_sof();
        tick();
        n_cmp++; if (done_cnt != d0 + 1 || done_cyc[$] != sc + 1) begin n_fail++; $display("FAIL partial_done: dones %0d at %0d want 1 at %0d", done_cnt - d0, done_cyc[$], sc + 1); end
        n_cmp++; if (pkt_size[$] != 3) begin n_fail++; $display("FAIL partial_size: got %0d want 3", pkt_size[$]); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rx_q[r0 + i] !== 8'(8'hA1 + i)) begin n_fail++; $display("FAIL partial_byte%0d: got %h want %h", i, rx_q[r0 + i], 8'(8'hA1 + i)); end
        end
        run(5);
        for (int i = 0; i < 3; i++) begin pulse_sof(); run(8); end
        n_cmp++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL partial_no_zlp: got %0d dones want 1", done_cnt - d0); end
        exp_pkts++;
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL partial_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
    endtask

    task automatic test_grant_drop();
        int d0, p0, r0;
        d0 = done_cnt; p0 = put_total; r0 = rx_q.size();
        for (int i = 0; i < 8; i++) send(8'(8'hC0 + i));
        for (int k = 0; k < 30 && put_total < p0 + 4; k++) tick();
        in_ep_grant = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL grant_ready: got %b want 0 at cycle %0d", s_ready, i); end
        end
        n_cmp++; if (put_total != p0 + 4 || done_cnt != d0) begin n_fail++; $display("FAIL grant_hold: puts %0d dones %0d want 4 and 0", put_total - p0, done_cnt - d0); end
        in_ep_grant = 1'b1;
        for (int k = 0; k < 30 && done_cnt == d0; k++) tick();
        n_cmp++; if (done_cnt != d0 + 1 || pkt_size[$] != 8) begin n_fail++; $display("FAIL grant_pkt: dones %0d size %0d want 1 and 8", done_cnt - d0, pkt_size[$]); end
        n_cmp++; if (done_cyc[$] != last_put_cyc + 1 || put_total != p0 + 8) begin n_fail++; $display("FAIL grant_done_lat: done %0d lastput %0d puts %0d", done_cyc[$], last_put_cyc, put_total - p0); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rx_q[r0 + i] !== 8'(8'hC0 + i)) begin n_fail++; $display("FAIL grant_byte%0d: got %h want %h", i, rx_q[r0 + i], 8'(8'hC0 + i)); end
        end
        run(5);
        pulse_sof(); run(2); pulse_sof(); run(6);
        n_cmp++; if (done_cnt != d0 + 2 || pkt_size[$] != 0) begin n_fail++; $display("FAIL grant_zlp: dones %0d size %0d want 2 and 0", done_cnt - d0, pkt_size[$]); end
        exp_pkts += 16'd2;
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL grant_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
    endtask

    task automatic test_coincident();
        int d0, p0, sc;
        d0 = done_cnt; p0 = put_total;
        for (int i = 0; i < 8; i++) send(8'(8'hD0 + i));
        for (int k = 0; k < 30 && put_total < p0 + 7; k++) tick();
        sc = cyc;
        pulse_sof();
        n_cmp++; if (last_put_cyc != sc || put_total != p0 + 8) begin n_fail++; $display("FAIL coinc_put: last put %0d want %0d", last_put_cyc, sc); end
        run(10);
        n_cmp++; if (done_cnt != d0 + 1 || done_cyc[$] != sc + 1) begin n_fail++; $display("FAIL coinc_one_done: dones %0d at %0d want 1 at %0d", done_cnt - d0, done_cyc[$], sc + 1); end
        pulse_sof();
        run(3);
        send(8'h5C);
        for (int k = 0; k < 10 && put_total < p0 + 9; k++) tick();
        pulse_sof();
        run(4);
        n_cmp++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL coinc_sof_clear: got %0d dones want 1", done_cnt - d0); end
        sc = cyc;
        pulse_sof();
        tick();
        n_cmp++; if (done_cnt != d0 + 2 || done_cyc[$] != sc + 1 || pkt_size[$] != 1) begin n_fail++; $display("FAIL coinc_flush: dones %0d size %0d want 2 and 1", done_cnt - d0, pkt_size[$]); end
        n_cmp++; if (rx_q[$] !== 8'h5C) begin n_fail++; $display("FAIL coinc_byte: got %h want 5c", rx_q[$]); end
        run(6);
        exp_pkts += 16'd2;
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL coinc_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
    endtask

    task automatic test_back_to_back();
        int d0, p0, r0, i0;
        d0 = done_cnt; p0 = put_total; r0 = rx_q.size(); i0 = pkt_size.size();
        ack_lat = 1;
        for (int i = 0; i < 20; i++) send(8'(8'hE0 + i));
        for (int k = 0; k < 100 && put_total < p0 + 20; k++) tick();
        run(2);
        pulse_sof(); run(2); pulse_sof(); run(6);
        for (int i = 0; i < 3; i++) begin pulse_sof(); run(8); end
        n_cmp++; if (done_cnt != d0 + 3) begin n_fail++; $display("FAIL b2b_count: got %0d packets want 3", done_cnt - d0); end
        if (done_cnt == d0 + 3) begin
            for (int j = 0; j < 3; j++) begin
                n_cmp++; if (pkt_size[i0 + j] != (j < 2 ? 8 : 4)) begin n_fail++; $display("FAIL b2b_size%0d: got %0d want %0d", j, pkt_size[i0 + j], (j < 2 ? 8 : 4)); end
            end
            n_cmp++; if (pkt_first[i0 + 1] - done_cyc[i0] != 3) begin n_fail++; $display("FAIL b2b_gap: got %0d want 3", pkt_first[i0 + 1] - done_cyc[i0]); end
        end
        for (int i = 0; i < 20 && r0 + i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[r0 + i] !== 8'(8'hE0 + i)) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[r0 + i], 8'(8'hE0 + i)); end
        end
        exp_pkts += 16'd3;
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL b2b_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
        ack_lat = 2;
    endtask

    task automatic test_random_stream();
        int L, d0, r0, i0;
        int exp_sz[$];
        logic [7:0] stream[$];
        valid_pct = 60;
        sof_period = 40;
        for (int t = 0; t < 4; t++) begin
            L = (t == 0) ? 16 : $urandom_range(1, 30);
            ack_lat = $urandom_range(1, 4);
            exp_sz.delete(); stream.delete();
            for (int i = 0; i < L / 8; i++) exp_sz.push_back(8);
            exp_sz.push_back(L % 8);
            d0 = done_cnt; r0 = rx_q.size(); i0 = pkt_size.size();
            for (int i = 0; i < L; i++) begin
                stream.push_back(8'($urandom));
                send(stream[i]);
            end
            for (int k = 0; k < 3000 && done_cnt < d0 + exp_sz.size(); k++) tick();
            run(120);
            n_cmp++; if (done_cnt != d0 + exp_sz.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d packets want %0d (L=%0d)", t, done_cnt - d0, exp_sz.size(), L); end
            for (int j = 0; j < exp_sz.size() && i0 + j < pkt_size.size(); j++) begin
                n_cmp++; if (pkt_size[i0 + j] != exp_sz[j]) begin n_fail++; $display("FAIL rand%0d_size%0d: got %0d want %0d", t, j, pkt_size[i0 + j], exp_sz[j]); end
            end
            for (int i = 0; i < L && r0 + i < rx_q.size(); i++) begin
                n_cmp++; if (rx_q[r0 + i] !== stream[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", t, i, rx_q[r0 + i], stream[i]); end
            end
            exp_pkts += 16'(exp_sz.size());
            n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL rand%0d_pkts: got %0d want %0d", t, pkts_sent, exp_pkts); end
        end
        valid_pct = 100;
        sof_period = 0;
        ack_lat = 2;
        run(4);
    endtask

    task automatic test_reset_wait_ack();
        int d0, p0;
        d0 = done_cnt; p0 = put_total;
        auto_ack = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
        for (int k = 0; k < 40 && done_cnt == d0; k++) tick();
        run(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", s_req); end
        n_cmp++; if (s_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", s_done); end
        cur.delete();
        exp_pkts = 16'd0;
        in_ep_acked = 1'b1;
        tick();
        run(3);
        n_cmp++; if (pkts_sent !== exp_pkts) begin n_fail++; $display("FAIL rst_pkts: got %0d want %0d", pkts_sent, exp_pkts); end
        for (int i = 0; i < 3; i++) begin pulse_sof(); run(4); end
        n_cmp++; if (done_cnt != d0 + 1 || s_req !== 1'b0) begin n_fail++; $display("FAIL rst_no_zlp: dones %0d req %b want 1 and 0", done_cnt - d0, s_req); end
        auto_ack = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_zlp();
        test_partial_flush();
        test_grant_drop();
        test_coincident();
        test_back_to_back();
        test_random_stream();
        test_reset_wait_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
